// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding, widths, NOP encoding and the register-match helper.
package hazard_ctrl_pkg;
  localparam int HC_REG_ADDR_W = 5;
  localparam logic [31:0] HC_NOP = 32'h0000_0013;
  typedef enum logic {RUN = 1'b0, HOLD1 = 1'b1} hc_state_t;
  function automatic logic reg_match(input logic use_src, input logic [HC_REG_ADDR_W-1:0] src,
                                     input logic wr, input logic [HC_REG_ADDR_W-1:0] dst);
    return use_src && wr && (dst != '0) && (src == dst);
  endfunction
endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: combinational RAW match of ID sources against EX/MEM producers.
// FWD_PATH_EN selects the forwarding variant (only an EX load stalls, one cycle).
module hazard_detect import hazard_ctrl_pkg::*; #(
  parameter int REG_ADDR_W = HC_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  output logic                  h1,
  output logic                  h2
);
  logic ex_hit, mem_hit;
  assign ex_hit  = reg_match(id_use_rs1, id_rs1, ex_reg_write, ex_rd) ||
                   reg_match(id_use_rs2, id_rs2, ex_reg_write, ex_rd);
  assign mem_hit = reg_match(id_use_rs1, id_rs1, mem_reg_write, mem_rd) ||
                   reg_match(id_use_rs2, id_rs2, mem_reg_write, mem_rd);
`ifdef FWD_PATH_EN
  logic unused_mem;
  assign unused_mem = mem_hit;
  assign h2 = 1'b0;
  assign h1 = ex_hit && ex_mem_read;
`else
  logic unused_ld;
  assign unused_ld = ex_mem_read;
  assign h2 = ex_hit;
  assign h1 = !ex_hit && mem_hit;
`endif
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW stall / branch squash controller with stall and flush counters.
// Build option FWD_PATH_EN (see hazard_detect) turns EX/MEM stalls into load-use-only stalls.
module hazard_ctrl import hazard_ctrl_pkg::*; #(
  parameter int REG_ADDR_W = HC_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  BranchTK,
  output logic                  stall,
  output logic                  stall_twice,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);
  hc_state_t state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic h1, h2;
  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .h1(h1), .h2(h2)
  );
  // HOLD1 holds unconditionally; a taken branch overrides any hold.
  always_comb begin
    stall        = !Reset && !BranchTK && (state_q == HOLD1 || h1 || h2);
    stall_twice  = !Reset && !BranchTK && state_q == RUN && h2;
    if_id_hold   = stall;
    if_id_flush  = !Reset && BranchTK;
    id_ex_bubble = stall || if_id_flush;
    state_d      = stall_twice ? HOLD1 : RUN;
    stall_cnt_d  = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
    flush_cnt_d  = flush_cnt_q + {{(CNT_W-1){1'b0}}, BranchTK};
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
endmodule
